// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: default widths and
// the operation codes chosen each cycle by the priority encoder.
package pc_seq_pkg;

    localparam int unsigned PC_ADDR_W      = 8;
    localparam int unsigned PC_STACK_DEPTH = 4;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_INC,
        OP_BR,
        OP_LOAD,
        OP_CALL,
        OP_RET,
        OP_ERR
    } pc_op_e;

    // Priority: call > ret > load > branch > inc. A call/ret conflict, an
    // overflowing call or an underflowing ret all collapse to OP_ERR.
    function automatic pc_op_e pc_decode(
        input logic call_pc,
        input logic ret_pc,
        input logic load_pc,
        input logic branch_pc,
        input logic inc_pc,
        input logic full,
        input logic empty
    );
        pc_op_e op;
        op = OP_NONE;
        if (call_pc && ret_pc)  op = OP_ERR;
        else if (call_pc)       op = full  ? OP_ERR : OP_CALL;
        else if (ret_pc)        op = empty ? OP_ERR : OP_RET;
        else if (load_pc)       op = OP_LOAD;
        else if (branch_pc)     op = OP_BR;
        else if (inc_pc)        op = OP_INC;
        return op;
    endfunction

endpackage

// File: rtl/pc_sequencer_ret_addr_stack.sv
// Return-address LIFO: register array indexed by the occupancy count.
// Overflow/underflow are the caller's responsibility.
module ret_addr_stack
    import pc_seq_pkg::*;
#(
    parameter int unsigned ADDR_W      = PC_ADDR_W,
    parameter int unsigned STACK_DEPTH = PC_STACK_DEPTH,
    localparam int unsigned DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [ADDR_W-1:0]  wdata,
    output logic [ADDR_W-1:0]  rdata,
    output logic [DEPTH_W-1:0] depth,
    output logic               full,
    output logic               empty
);

    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0]  r_mem [STACK_DEPTH];
    logic [DEPTH_W-1:0] r_depth;
    logic [IDX_W-1:0]   w_wr_idx;
    logic [IDX_W-1:0]   w_rd_idx;

    assign w_wr_idx = IDX_W'(r_depth);
    assign w_rd_idx = IDX_W'(r_depth - 1'b1);

    // Contents need no reset; only the occupancy count is meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[w_wr_idx] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_depth <= '0;
        end else if (push) begin
            r_depth <= r_depth + 1'b1;
        end else if (pop) begin
            r_depth <= r_depth - 1'b1;
        end
    end

    assign rdata = r_mem[w_rd_idx];
    assign depth = r_depth;
    assign full  = (r_depth == DEPTH_W'(STACK_DEPTH));
    assign empty = (r_depth == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with load, increment, relative branch, call/return and a
// hardware return-address stack; one operation per clock.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned      ADDR_W      = PC_ADDR_W,
    parameter int unsigned      STACK_DEPTH = PC_STACK_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    localparam int unsigned     DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_pc,
    input  logic               inc_pc,
    input  logic               branch_pc,
    input  logic               call_pc,
    input  logic               ret_pc,
    input  logic [ADDR_W-1:0]  data_in,
    input  logic [ADDR_W-1:0]  offset,
    output logic [ADDR_W-1:0]  count,
    output logic [DEPTH_W-1:0] depth,
    output logic               stack_full,
    output logic               stack_empty,
    output logic               stack_err
);

    pc_op_e            w_op;
    logic [ADDR_W-1:0] r_count;
    logic              r_err;
    logic [ADDR_W-1:0] w_count_inc;
    logic [ADDR_W-1:0] w_count_br;
    logic [ADDR_W-1:0] w_ret_addr;
    logic              w_full;
    logic              w_empty;

    assign w_op = pc_decode(call_pc, ret_pc, load_pc, branch_pc, inc_pc, w_full, w_empty);

    // Same-width add is exactly the sign-extended add modulo 2^ADDR_W.
    assign w_count_inc = r_count + 1'b1;
    assign w_count_br  = r_count + offset;

    ret_addr_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (w_op == OP_CALL),
        .pop   (w_op == OP_RET),
        .wdata (w_count_inc),
        .rdata (w_ret_addr),
        .depth (depth),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= RESET_ADDR;
            r_err   <= 1'b0;
        end else begin
            case (w_op)
                OP_INC:           r_count <= w_count_inc;
                OP_BR:            r_count <= w_count_br;
                OP_LOAD, OP_CALL: r_count <= data_in;
                OP_RET:           r_count <= w_ret_addr;
                OP_ERR:           r_err   <= 1'b1;
                default:          ;
            endcase
        end
    end

    assign count       = r_count;
    assign stack_full  = w_full;
    assign stack_empty = w_empty;
    assign stack_err   = r_err;

endmodule
